// File: rtl/pick_arbiter.sv
// Four-requester valid/ready arbiter feeding one registered output word.
// Optional build macro PICK_ARB_FIXED_PRIO_EN: index 0 always has top priority, no rotation pointer.
module pick_arbiter #(
  parameter int DATA_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req_valid,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_sel
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        base;
  logic [1:0]        grant;
  logic [1:0]        idx;
  logic              found;
  logic              any_req;
  logic              load_en;
  logic              xfer;
  logic [DATA_W-1:0] req_word [4];

`ifdef PICK_ARB_FIXED_PRIO_EN
  assign base = 2'd0;
`else
  logic [1:0] ptr_q, ptr_d;

  // The pointer only moves past a requester that actually won a transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = grant + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign base = ptr_q;
`endif

  assign any_req = |req_valid;
  assign load_en = !full_q || out_ready;
  assign xfer    = load_en && any_req && !rst;

  // Search from the priority base upward, wrapping modulo 4.
  always_comb begin
    grant = base;
    idx   = base;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && req_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_req
      assign req_word[gi]  = req_data[gi*DATA_W +: DATA_W];
      assign req_ready[gi] = xfer && (grant == 2'(gi));
    end
  endgenerate

  // A new load wins over a drain, so back-to-back words never bubble.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    sel_d  = sel_q;
    if (xfer) begin
      full_d = 1'b1;
      data_d = req_word[grant];
      sel_d  = grant;
    end else if (out_ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      sel_q  <= 2'd0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      sel_q  <= sel_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_pick_arbiter.sv
// Randomized and directed bench for pick_arbiter against a cycle-level reference model.
module tb_pick_arbiter;

  localparam int DATA_W = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         req_valid;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]         req_ready;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [1:0]         out_sel;

  pick_arbiter #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: buffer contents and rotation pointer.
  int m_full = 0;
  int m_data = 0;
  int m_sel  = 0;
  int m_ptr  = 0;
  int waitc [4];
  int last_grant;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [3:0] v);
    int start;
`ifdef PICK_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < 4; k++) begin
      if (v[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic run_cycle(input logic r, input logic [3:0] v, input logic [7:0] d, input logic ordy);
    int g;
    bit go;
    logic [3:0] exp_rdy;
    rst       = r;
    req_valid = v;
    req_data  = d;
    out_ready = ordy;
    @(negedge clk);
    g  = model_grant(v);
    go = !r && (m_full == 0 || ordy) && (g >= 0);
    exp_rdy = go ? 4'(1 << g) : 4'b0000;
    check("req_ready", req_ready, exp_rdy);
    check("out_valid", out_valid, m_full);
    check("out_data",  out_data,  m_data);
    check("out_sel",   out_sel,   m_sel);
    last_grant = go ? g : -1;
    if (go) begin
`ifndef PICK_ARB_FIXED_PRIO_EN
      check("wait_bound", waitc[g] <= 3, 1);
`endif
      for (int i = 0; i < 4; i++) begin
        if (i == g) waitc[i] = 0;
        else if (v[i]) waitc[i]++;
      end
      $display("xfer req %0d data %0d", g, (d >> (2 * g)) & 8'h3);
    end
    if (r) begin
      m_full = 0; m_data = 0; m_sel = 0; m_ptr = 0;
      for (int i = 0; i < 4; i++) waitc[i] = 0;
    end else if (go) begin
      m_full = 1;
      m_data = (d >> (2 * g)) & 3;
      m_sel  = g;
`ifndef PICK_ARB_FIXED_PRIO_EN
      m_ptr  = (g + 1) % 4;
`endif
    end else if (ordy) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  logic [3:0] pend;
  logic [7:0] pdata;

  initial begin
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    rst = 1'b1; req_valid = 4'b0; req_data = 8'h0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    run_cycle(1'b1, 4'b0000, 8'h00, 1'b0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sel",   out_sel,   0);

    // Full request, words equal to their index.
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 4'b1111, 8'b11_10_01_00, 1'b1);
    run_cycle(1'b0, 4'b0000, 8'h00, 1'b1);

    // Single request then stall, then drain.
    run_cycle(1'b0, 4'b0100, 8'b00_10_00_00, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 4'b0000, 8'h00, 1'b0);
    run_cycle(1'b0, 4'b0000, 8'h00, 1'b1);

    // Load into a full buffer that drains the same cycle.
    run_cycle(1'b0, 4'b0001, 8'b00_00_00_01, 1'b1);
    run_cycle(1'b0, 4'b1000, 8'b11_00_00_00, 1'b1);
    run_cycle(1'b0, 4'b0000, 8'h00, 1'b1);

    // Pointer wrap from 3 back to 0.
    run_cycle(1'b0, 4'b1000, 8'b10_00_00_00, 1'b1);
    run_cycle(1'b0, 4'b1001, 8'b01_00_00_11, 1'b1);
    run_cycle(1'b0, 4'b1000, 8'b01_00_00_00, 1'b1);

    // Reset during a stall.
    run_cycle(1'b0, 4'b0010, 8'b00_00_11_00, 1'b0);
    run_cycle(1'b0, 4'b0000, 8'h00, 1'b0);
    run_cycle(1'b1, 4'b0110, 8'b00_11_10_00, 1'b0);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_data",  out_data,  0);
    run_cycle(1'b0, 4'b0110, 8'b00_11_10_00, 1'b1);

    // Idle: no grants, pointer must not move.
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 4'b0000, 8'h00, 1'b1);
    run_cycle(1'b0, 4'b1111, 8'b11_10_01_00, 1'b1);
    run_cycle(1'b0, 4'b0000, 8'h00, 1'b1);

    // Random traffic; requesters hold their word until accepted.
    pend  = 4'b0;
    pdata = 8'h0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pdata[2*i +: 2] = 2'($urandom_range(0, 3));
        end
      end
      run_cycle($urandom_range(0, 99) == 0, pend, pdata, $urandom_range(0, 3) != 0);
      if (last_grant >= 0) pend[last_grant] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pick_arbiter.md
# pick_arbiter

Round-robin arbiter that shares one `DATA_W`-bit output channel among four requesters. Each requester has its own valid/ready handshake. The arbiter selects one requester, drives the 2-bit select of a 4:1 data mux (same key layout as the `pick` mux: select 00..11 maps to x0..x3), and registers the chosen word into a single output buffer. It sits between producer ports and a shared consumer in the npc datapath.

## Interface
- `DATA_W`, default 2: width of each request word and of `out_data`.
- `clk`  in  1: clock, all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  4: bit i = requester i has a word.
- `req_data`  in  4*DATA_W: requester i word at bits [DATA_W*(i+1)-1 : DATA_W*i].
- `req_ready`  out  4: bit i = word i accepted this cycle; one-hot or zero.
- `out_valid`  out  1: output buffer holds a word.
- `out_ready`  in  1: consumer accepts the word.
- `out_data`  out  DATA_W: buffered word.
- `out_sel`  out  2: index of the requester that produced `out_data`.

One clock; reset is synchronous and active-high.

## Operation
- State is two registers: `full` (drives `out_valid`) and round-robin pointer `ptr[1:0]` (the highest-priority index).
- `load_en = !full || out_ready`.
- Grant logic is combinational. It searches `req_valid` starting at `ptr` and wraps in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first set bit is `g`. `any = |req_valid`.
- `req_ready[i] = load_en && any && (i == g)`. All bits are 0 otherwise.
- Transfer on requester i happens when `req_valid[i] && req_ready[i]`.
- On a transfer in the cycle:
  - `out_data <= req_data` slice `g`.
  - `out_sel <= g`.
  - `full <= 1`.
  - `ptr <= g + 1` (2-bit wrap: 3 goes to 0).
- If `full && out_ready` and there is no new transfer: `full <= 0`. `out_data` and `out_sel` hold their last values.
- If `full && !out_ready`: all registers hold and `req_ready` is 0. Requesters must keep `req_valid` and `req_data` stable until accepted.
- Simultaneous drain and load (`full && out_ready && any`): the new word replaces the old one and `full` stays 1. Sustained throughput is one word per cycle.
- `ptr` advances only on a transfer. Idle cycles and stall cycles do not move it.
- No requester waits more than 3 grants while it holds `req_valid`.

## Timing
- Reset values:
  - `out_valid = 0`
  - `out_data = 0`
  - `out_sel = 0`
  - `ptr = 0`
  - `req_ready = 0`, because it is gated by `any`.
- Latency: a word accepted in cycle N appears with `out_valid = 1` in cycle N+1.
- There is a combinational path `out_ready -> req_ready` (through `load_en`) and a combinational path `req_valid -> req_ready`. There is no combinational path to `out_valid`, `out_data` or `out_sel`.
- Reset asserted mid-transfer takes priority over everything. A buffered word is discarded, and `req_ready` is 0 while `rst = 1`.
- If `req_valid` drops before it is accepted (a protocol violation), the arbiter regrants next cycle with no error state.

## Configuration
- `PICK_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. The search always starts at index 0 (lowest index wins), and `ptr` is not implemented (held 0). Starvation is possible.
  - Undefined (default): round-robin exactly as in Operation.
  - Handshake, latency and buffering are identical in both builds.

## Test plan
- Reset, then `req_valid = 4'b1111`, `out_ready = 1`, data words x0..x3 = 0,1,2,3, `DATA_W = 2`:
  - Required: `out_sel` sequence 0,1,2,3,0 on consecutive cycles starting the cycle after reset release.
  - Required: `out_data` equals `out_sel`.
  - With macro defined: `out_sel` stays 0.
- `req_valid = 4'b0100`, then `out_ready = 0` for 3 cycles:
  - Required: one transfer, then `out_valid = 1`, `out_sel = 2`, `out_data` held, `req_ready = 0` during the stall.
  - When `out_ready` is raised: drained in that cycle.
- `full = 1`, `out_ready = 1`, `req_valid = 4'b1000` in the same cycle:
  - Required: `req_ready = 4'b1000`.
  - Next cycle: `out_valid = 1`, `out_sel = 3`, with no bubble.
- Pointer wrap:
  - Grant requester 3 alone.
  - Then `req_valid = 4'b1001`: required grant 0 (`ptr = 0`). Then grant 3.
- Reset mid-stall:
  - Hold `out_valid = 1`, `out_ready = 0`, then assert `rst` for 1 cycle.
  - Required next cycle: `out_valid = 0`, `out_data = 0`, `out_sel = 0`, and the first grant after reset goes to the lowest valid index.
- Idle with no requests:
  - Required: `req_ready = 0`, `out_valid` falls one cycle after drain, and `ptr` is unchanged (checked by the next grant order).
